// File: rtl/cpu_sequencer_if.sv
// Memory read handshake between the sequencer (master) and instruction memory (slave).
interface cpu_sequencer_if #(
  parameter int DATA_W = 16
);
  logic              mem_req;
  logic              mem_ack;
  logic [DATA_W-1:0] bus;

  modport master (output mem_req, input mem_ack, input bus);
  modport slave  (input mem_req, output mem_ack, output bus);
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle control unit: fetches over a req/ack handshake, decodes the IR and
// drives PC, register-file and ALU strobes. Strobes are decoded from registered state.
module cpu_sequencer #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic                   zero_flag,
  cpu_sequencer_if.master        mem,
  output logic                   pc_enable,
  output logic                   pc_select,
  output logic                   reg_we,
  output logic                   imm_sel,
  output logic [2:0]             rd_sel,
  output logic [2:0]             rs_sel,
  output logic [1:0]             alu_op,
  output logic                   halted,
  output logic                   illegal,
  output logic                   bus_err,
  output logic [2:0]             state
);
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXEC    = 3'd3,
    S_OPERAND = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_LDI  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_JMP  = 4'd4;
  localparam logic [3:0] OP_JZ   = 4'd5;
  localparam logic [3:0] OP_HALT = 4'd6;
  localparam logic [7:0] LIMIT   = 8'(WAIT_LIMIT);

  state_t      st;
  logic [15:0] ir;
  logic [7:0]  wait_cnt;
  logic [3:0]  opcode;
  logic        limit_hit;
  logic        op_ack;

  // Saturating increment: the wait counter parks at the limit instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v >= LIMIT) ? v : v + 8'd1;
  endfunction

  assign opcode    = ir[15:12];
  assign limit_hit = (sat_inc(wait_cnt) >= LIMIT);
  assign op_ack    = (st == S_OPERAND) && mem.mem_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= S_IDLE;
      ir       <= '0;
      wait_cnt <= '0;
      illegal  <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      case (st)
        S_IDLE: begin
          wait_cnt <= '0;
          if (run) st <= S_FETCH;
        end
        S_FETCH, S_OPERAND: begin
          if (mem.mem_ack) begin
            wait_cnt <= '0;
            if (st == S_FETCH) begin
              ir <= mem.bus;
              st <= S_DECODE;
            end else begin
              st <= S_FETCH;
            end
          end else begin
            wait_cnt <= sat_inc(wait_cnt);
            if (limit_hit) begin
              bus_err <= 1'b1;
              st      <= S_HALT;
            end
          end
        end
        S_DECODE: begin
          wait_cnt <= '0;
          case (opcode)
            OP_NOP:                st <= S_FETCH;
            OP_ADD, OP_SUB:        st <= S_EXEC;
            OP_LDI, OP_JMP, OP_JZ: st <= S_OPERAND;
            OP_HALT:               st <= S_HALT;
            default: begin
              illegal <= 1'b1;
              st      <= S_HALT;
            end
          endcase
        end
        S_EXEC: begin
          wait_cnt <= '0;
          st       <= S_FETCH;
        end
        S_HALT:  st <= S_HALT;
        default: st <= S_IDLE;
      endcase
    end
  end

  // Strobe decode from registered state, IR and the live ack.
  assign mem.mem_req = (st == S_FETCH) || (st == S_OPERAND);
  assign pc_enable   = ((st == S_FETCH) && mem.mem_ack) || op_ack;
  assign pc_select   = op_ack && ((opcode == OP_JMP) || ((opcode == OP_JZ) && zero_flag));
  assign reg_we      = (st == S_EXEC) || (op_ack && (opcode == OP_LDI));
  assign imm_sel     = op_ack && (opcode == OP_LDI);
  assign alu_op      = (st != S_EXEC) ? 2'b00 : (opcode == OP_ADD) ? 2'b01 : 2'b10;
  assign rd_sel      = ir[11:9];
  assign rs_sel      = ir[8:6];
  assign halted      = (st == S_HALT);
  assign state       = st;
endmodule
